branch_target_buffer: RTL
=========================

Name: branch_target_buffer

Overview:
- Fetch-side branch predictor. Consumes the resolved-branch update bus produced by the execute stage (is_branch_pype2, PC_pype2, branch_BTB_contral, branch_BTB_PC, branch_miss_contral).
- Supplies the fetch stage with a same-cycle taken/not-taken prediction and next PC. The prediction travels down the pipe as is_branch_predict_pype1 / PC_Np_pype1.
- Direct-mapped table; each entry holds valid, tag, target and a 2-bit saturating counter. Also keeps branch and mispredict statistics counters.

Parameters:
- BTB_IDX_W, 4, index width; table has 2**BTB_IDX_W entries. Index = PC[BTB_IDX_W+1:2]; tag = PC[31:BTB_IDX_W+2].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset (negedge rst).
- keep  input  1  pipeline stall; while high, no table or counter update.
- btb_clear  input  1  synchronous invalidate of all entries (e.g. fence.i).
- PC_if  input  32  current fetch PC.
- is_branch_predict  output  1  predicted taken for PC_if.
- PC_Np  output  32  predicted next fetch PC.
- is_branch_pype2  input  1  resolved instruction is a branch or jump.
- PC_pype2  input  32  PC of the resolved instruction.
- branch_BTB_contral  input  1  resolved instruction actually redirected.
- branch_BTB_PC  input  32  actual redirect target (valid when branch_BTB_contral=1).
- branch_miss_contral  input  1  execute-stage mispredict redirect.
- branch_count  output  32  number of accepted branch updates.
- miss_count  output  32  number of accepted mispredicts.

Behaviour:
- Reset (rst=0, asynchronous):
  - every entry: valid=0, tag=0, target=0, ctr=2'b01.
  - branch_count=0, miss_count=0.
  - Outputs after reset: is_branch_predict=0, PC_Np=PC_if+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==PC_if tag.
  - is_branch_predict = hit && ctr[idx][1].
  - PC_Np = is_branch_predict ? target[idx] : PC_if+4. Add is 32-bit modulo: PC 0xFFFF_FFFC gives 0x0000_0000.
- Update enable: upd = is_branch_pype2 && !keep && !btb_clear, evaluated at posedge using PC_pype2's index and tag.
- Update on hit:
  - Taken (branch_BTB_contral=1): ctr=min(ctr+1,3) and target=branch_BTB_PC.
  - Not taken: ctr=max(ctr-1,0); target unchanged; valid stays 1.
- Update on miss:
  - Taken: allocate. valid=1, tag, target=branch_BTB_PC, ctr=2'b10 (weakly taken). Overwrites any conflicting entry.
  - Not taken: no change.
- Misaligned target: if branch_BTB_contral=1 and branch_BTB_PC[1:0]!=0, the entry is not written at all (exception path). Statistics counters still count it.
- Non-branch redirects (ecall/mret: is_branch_pype2=0, branch_BTB_contral=1) never touch the table.
- btb_clear: all valid bits go to 0 on the next posedge. Counters, tags and targets are untouched. It takes priority over a same-cycle update, and that update is dropped.
- Same-cycle lookup and update to the same index: lookup sees the pre-update contents (no bypass). The new value is visible from the next cycle.
- Statistics:
  - branch_count += 1 when upd.
  - miss_count += 1 when branch_miss_contral && !keep. This includes csr redirects.
  - Both counters wrap modulo 2**32.
- keep held for N cycles with constant pype2 inputs gives exactly one update, applied on the first posedge with keep=0.
- Reset asserted mid-operation clears all state immediately, regardless of keep or btb_clear.

Test Plan:
- Reset, then PC_if=0x100 -> is_branch_predict=0, PC_Np=0x104, branch_count=0, miss_count=0.
- Taken update: PC_pype2=0x100, is_branch_pype2=1, branch_BTB_contral=1, branch_BTB_PC=0x200, branch_miss_contral=1 for one cycle. Then PC_if=0x100 -> is_branch_predict=1, PC_Np=0x200, branch_count=1, miss_count=1.
- Hysteresis: from that state, two not-taken updates at 0x100 -> ctr 2->1->0. Prediction is 0 (PC_Np=0x104) after the first update. Then three taken updates -> ctr saturates at 3 after the third; a fourth leaves ctr at 3.
- Aliasing: with entry at 0x100 valid, a taken update at 0x140 (same index, BTB_IDX_W=4) with target 0x300 -> PC_if=0x100 gives PC_Np=0x104; PC_if=0x140 gives PC_Np=0x300.
- keep and misalignment:
  - keep=1 for 3 cycles with a taken update presented -> no table change and branch_count unchanged until keep falls, then exactly +1.
  - branch_BTB_PC=0x202 -> no allocation; branch_count still increments.
- Clear collision: btb_clear=1 in the same cycle as a taken update at 0x100 -> all entries invalid, PC_if=0x100 gives PC_Np=0x104. Asynchronous reset mid-stream returns all state to reset values.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. It gives a zero-latency taken/next-PC prediction
// to fetch, learns from resolved branches in execute, and counts branches and mispredicts.
module branch_target_buffer #(
    parameter int BTB_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        btb_clear,
    input  logic [31:0] PC_if,
    output logic        is_branch_predict,
    output logic [31:0] PC_Np,
    input  logic        is_branch_pype2,
    input  logic [31:0] PC_pype2,
    input  logic        branch_BTB_contral,
    input  logic [31:0] branch_BTB_PC,
    input  logic        branch_miss_contral,
    output logic [31:0] branch_count,
    output logic [31:0] miss_count
);

    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = 32 - BTB_IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Lookup: reads only registered state, so a same-cycle update is not bypassed.
    logic [BTB_IDX_W-1:0] lidx;
    logic [TAG_W-1:0]     ltag;
    logic                 lhit;

    assign lidx              = PC_if[BTB_IDX_W+1:2];
    assign ltag              = PC_if[31:BTB_IDX_W+2];
    assign lhit              = valid_q[lidx] && (tag_q[lidx] == ltag);
    assign is_branch_predict = lhit && ctr_q[lidx][1];
    assign PC_Np             = is_branch_predict ? target_q[lidx] : PC_if + 32'd4;

    logic [BTB_IDX_W-1:0] uidx;
    logic [TAG_W-1:0]     utag;
    logic                 upd;
    logic                 uhit;
    logic                 misaligned;
    logic                 wr_en;
    logic [1:0]           wr_ctr;
    logic [31:0]          wr_target;

    assign uidx       = PC_pype2[BTB_IDX_W+1:2];
    assign utag       = PC_pype2[31:BTB_IDX_W+2];
    assign upd        = is_branch_pype2 && !keep && !btb_clear;
    assign uhit       = valid_q[uidx] && (tag_q[uidx] == utag);
    // A taken branch to a misaligned target traps, so it must not train the table.
    assign misaligned = branch_BTB_contral && (branch_BTB_PC[1:0] != 2'b00);

    always_comb begin
        wr_en     = 1'b0;
        wr_ctr    = ctr_q[uidx];
        wr_target = target_q[uidx];
        if (upd && !misaligned) begin
            if (uhit) begin
                wr_en = 1'b1;
                if (branch_BTB_contral) begin
                    wr_ctr    = sat_inc(ctr_q[uidx]);
                    wr_target = branch_BTB_PC;
                end else begin
                    wr_ctr = sat_dec(ctr_q[uidx]);
                end
            end else if (branch_BTB_contral) begin
                wr_en     = 1'b1;
                wr_ctr    = 2'b10;
                wr_target = branch_BTB_PC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (btb_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[uidx]  <= 1'b1;
            tag_q[uidx]    <= utag;
            target_q[uidx] <= wr_target;
            ctr_q[uidx]    <= wr_ctr;
        end
    end

    // Mispredict statistics ignore btb_clear: only a stall suppresses them.
    assign branch_count_d = upd ? branch_count_q + 32'd1 : branch_count_q;
    assign miss_count_d   = (branch_miss_contral && !keep) ? miss_count_q + 32'd1 : miss_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_count_q <= '0;
            miss_count_q   <= '0;
        end else begin
            branch_count_q <= branch_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign branch_count = branch_count_q;
    assign miss_count   = miss_count_q;

endmodule
